rv32_decode_stage: RTL and testbench
====================================

# rv32_decode_stage

Registered RV32I instruction decode stage that turns a fetched 32-bit instruction into the control word consumed by the ALU: the 4-bit ALU opcode, register addresses, immediate and operand-select flags. It sits between instruction fetch and execute and drives the ALU's opcode input directly. Both sides use valid/ready handshakes, and a flush input discards in-flight work on redirect.

## Interface

Parameters:
- none

Ports:
- `clk_in` — input, 1 — rising-edge clock.
- `rst_n_in` — input, 1 — **synchronous, active-low** reset.
- `flush_in` — input, 1 — discard all held instructions this cycle.
- `in_valid_in` — input, 1 — fetch presents an instruction.
- `in_ready_out` — output, 1 — stage accepts the instruction this cycle.
- `instr_in` — input, 32 — instruction word.
- `pc_in` — input, 32 — instruction address.
- `out_valid_out` — output, 1 — decoded word valid.
- `out_ready_in` — input, 1 — execute accepts the decoded word.
- `pc_out` — output, 32 — registered `pc_in`.
- `alu_opcode_out` — output, 4 — ALU operation.
- `rs1_addr_out`, `rs2_addr_out`, `rd_addr_out` — output, 5 each — register indices.
- `imm_out` — output, 32 — sign-extended immediate.
- `op2_sel_imm_out` — output, 1 — ALU operand 2 is the immediate, not rs2.
- `reg_write_out` — output, 1 — rd is written.
- `illegal_out` — output, 1 — unsupported encoding.

## Operation

- **Transfers.**
  - Input transfer: `in_valid_in && in_ready_out`.
  - Output transfer: `out_valid_out && out_ready_in`.
- **ALU opcode encoding** (`{bit3, funct3}`):
  - 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 0100 XOR, 0110 OR, 0111 AND, 0001 SLL, 0101 SRL, 1101 SRA.
- **OP (0110011):**
  - `alu_opcode_out = {instr[30], funct3}`.
  - `op2_sel_imm_out = 0`, `reg_write_out = 1`.
- **OP-IMM (0010011):**
  - bit3 = `instr[30]` only when funct3 = 101; otherwise bit3 = 0.
  - `op2_sel_imm_out = 1`.
  - Shifts: `imm_out = {27'b0, instr[24:20]}`.
- **LOAD, STORE, JAL, JALR, LUI, AUIPC:**
  - `alu_opcode_out = 0000`.
  - `op2_sel_imm_out = 1`.
  - `reg_write_out = 0` for STORE; 1 for the others.
- **BRANCH:**
  - BEQ/BNE → 1000; BLT/BGE → 0010; BLTU/BGEU → 0011.
  - `op2_sel_imm_out = 0`, `reg_write_out = 0`.
- **Immediates:** I/S/B/U/J formats per RV32I, sign-extended from bit 31.
- **Illegal encodings:**
  - Covers any other opcode, and an OP with `instr[31:25]` not 0000000/0100000.
  - Output: `illegal_out = 1`, `reg_write_out = 0`, `alu_opcode_out = 0000`.
  - The word still flows through the handshake.
- **Field passthrough:**
  - Fields `rs1`/`rs2`/`rd` are always passed raw from `instr[19:15]`, `[24:20]`, `[11:7]`.

## Timing

- **Latency:** 1 cycle from input transfer to `out_valid_out`.
- **Reset:** all outputs 0 (including `in_ready_out`) on the cycle reset is sampled low.
  - `in_ready_out` rises the first cycle after release.
- **Flush:**
  - Clears all held entries at the clock edge.
  - `out_valid_out = 0` next cycle.
  - `in_ready_out` is forced 0 during the flush cycle, so no instruction is accepted.
  - Flush takes priority over simultaneous input and output transfers.
- **Holding:** output fields hold stable while `out_valid_out && !out_ready_in`.
- **Simultaneous transfers:** an input and an output transfer in the same cycle replace the entry with no bubble.
- **Throughput:** 1 instruction/cycle when `out_ready_in` is held high.
- **Reset mid-operation:** any held instruction is dropped; no partial output.

## Configuration

- **`RV32_DECODE_SKID_EN` defined:**
  - Two-entry skid buffer.
  - `in_ready_out` is a pure register output: high when the skid entry is empty.
  - One extra instruction is absorbed after `out_ready_in` drops.
  - Skid contents drain before new input is accepted.
- **`RV32_DECODE_SKID_EN` undefined:**
  - Single output register.
  - `in_ready_out = !out_valid_out || out_ready_in`, which is combinational from `out_ready_in`.
  - Otherwise functionally identical.

## Test plan

- **ADD x3,x1,x2** (0x002081B3) with `out_ready_in = 1`:
  - One cycle later: opcode 0000, rs1 = 1, rs2 = 2, rd = 3, `op2_sel_imm_out = 0`, `reg_write_out = 1`.
- **SUB 0x402081B3** → opcode 1000.
- **SRAI x5,x6,4 (0x40435293)** → opcode 1101, `imm_out = 0x00000004`, `op2_sel_imm_out = 1`.
- **ADDI x1,x0,-1 (0xFFF00093)** → `imm_out = 0xFFFFFFFF`, opcode 0000.
- **BLTU (0x0020E463)** → opcode 0011, `reg_write_out = 0`, `imm_out = 0x00000008`.
- **Illegal 0x00000000** → `illegal_out = 1`, `reg_write_out = 0`.
- **Backpressure:** hold `out_ready_in = 0` for 5 cycles while streaming 4 instructions.
  - No loss or duplication; the in-order sequence is checked against a scoreboard.
  - Flush mid-stream leaves `out_valid_out = 0` the next cycle.
- **Reset:** assert `rst_n_in = 0` with a valid output held → all outputs 0 the next cycle.

Source files
------------

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: registered RV32I decode stage feeding the ALU.
// Turns a fetched instruction into the ALU control word: opcode, register
// indices, sign-extended immediate and operand/write-back flags.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high on that side; valid never waits on ready, and a producer holds
// its payload stable until the transfer completes.
//
// Build option: define RV32_DECODE_SKID_EN for a two-entry skid buffer with
// a registered in_ready_out. Without it a single output register is used and
// in_ready_out is combinational from out_ready_in.
module rv32_decode_stage (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        flush_in,
   input  logic        in_valid_in,
   output logic        in_ready_out,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   output logic        out_valid_out,
   input  logic        out_ready_in,
   output logic [31:0] pc_out,
   output logic [3:0]  alu_opcode_out,
   output logic [4:0]  rs1_addr_out,
   output logic [4:0]  rs2_addr_out,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] imm_out,
   output logic        op2_sel_imm_out,
   output logic        reg_write_out,
   output logic        illegal_out
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // One decoded instruction as it is held in the stage.
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu_op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        op2_imm;
      logic        reg_write;
      logic        illegal;
   } dec_word_t;

   dec_word_t   dec;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign opc   = instr_in[6:0];
   assign f3    = instr_in[14:12];
   assign f7    = instr_in[31:25];
   assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
   assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
   assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                   instr_in[30:25], instr_in[11:8], 1'b0};
   assign imm_u = {instr_in[31:12], 12'b0};
   assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                   instr_in[20], instr_in[30:21], 1'b0};

   // Combinational decode of the presented instruction into a control word.
   always_comb begin
      dec           = '0;
      dec.pc        = pc_in;
      dec.rs1       = instr_in[19:15];
      dec.rs2       = instr_in[24:20];
      dec.rd        = instr_in[11:7];
      case (opc)
         OPC_OP: begin
            if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
               dec.alu_op    = {instr_in[30], f3};
               dec.reg_write = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            // Only shift-right uses bit 30 as an opcode bit; elsewhere it is
            // part of the immediate.
            dec.alu_op    = {(f3 == 3'b101) & instr_in[30], f3};
            dec.op2_imm   = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = (f3[1:0] == 2'b01) ? {27'b0, instr_in[24:20]} : imm_i;
         end
         OPC_LOAD, OPC_JALR: begin
            dec.op2_imm   = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = imm_i;
         end
         OPC_STORE: begin
            dec.op2_imm = 1'b1;
            dec.imm     = imm_s;
         end
         OPC_JAL: begin
            dec.op2_imm   = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = imm_j;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.op2_imm   = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = imm_u;
         end
         OPC_BRANCH: begin
            // Equality compares subtract; signed/unsigned use SLT/SLTU.
            if (!f3[2]) dec.alu_op = 4'b1000;
            else        dec.alu_op = f3[1] ? 4'b0011 : 4'b0010;
            dec.imm = imm_b;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   dec_word_t word;

`ifdef RV32_DECODE_SKID_EN
   dec_word_t main_q;
   dec_word_t skid_q;
   logic      main_v_q;
   logic      skid_v_q;
   logic      ready_q;
   dec_word_t main_d;
   dec_word_t skid_d;
   logic      main_v_d;
   logic      skid_v_d;
   logic      accept;

   assign accept        = in_valid_in && ready_q && !flush_in;
   assign in_ready_out  = ready_q;
   assign out_valid_out = main_v_q;
   assign word          = main_q;

   // Next-state of the main/skid pair; skid drains into main before any new input.
   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      if (flush_in) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q || out_ready_in) begin
         if (skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
         end else if (accept) begin
            main_d   = dec;
            main_v_d = 1'b1;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (accept) begin
         skid_d   = dec;
         skid_v_d = 1'b1;
      end
   end

   // State registers; ready is registered as "skid will be empty".
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         ready_q  <= !skid_v_d;
      end
   end
`else
   dec_word_t out_q;
   logic      out_v_q;
   logic      accept;

   assign in_ready_out  = rst_n_in && !flush_in && (!out_v_q || out_ready_in);
   assign accept        = in_valid_in && in_ready_out;
   assign out_valid_out = out_v_q;
   assign word          = out_q;

   // Single output register: load on accept, empty on drain, clear on flush.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         out_q   <= '0;
         out_v_q <= 1'b0;
      end else if (flush_in) begin
         out_q   <= '0;
         out_v_q <= 1'b0;
      end else if (accept) begin
         out_q   <= dec;
         out_v_q <= 1'b1;
      end else if (out_ready_in) begin
         out_v_q <= 1'b0;
      end
   end
`endif

   assign pc_out          = word.pc;
   assign alu_opcode_out  = word.alu_op;
   assign rs1_addr_out    = word.rs1;
   assign rs2_addr_out    = word.rs2;
   assign rd_addr_out     = word.rd;
   assign imm_out         = word.imm;
   assign op2_sel_imm_out = word.op2_imm;
   assign reg_write_out   = word.reg_write;
   assign illegal_out     = word.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed testbench for rv32_decode_stage (default build, single output register).
module tb_rv32_decode_stage;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        flush_in;
   logic        in_valid_in;
   logic        in_ready_out;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        out_valid_out;
   logic        out_ready_in;
   logic [31:0] pc_out;
   logic [3:0]  alu_opcode_out;
   logic [4:0]  rs1_addr_out;
   logic [4:0]  rs2_addr_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] imm_out;
   logic        op2_sel_imm_out;
   logic        reg_write_out;
   logic        illegal_out;

   int checks   = 0;
   int failures = 0;

   localparam int NV = 11;
   localparam int W  = 41;

   // Hand-decoded vectors: instr, opcode, rs1, rs2, rd, imm, op2_imm, reg_write, illegal.
   logic [31:0] v_instr [NV] = '{32'h002081B3, 32'h402081B3, 32'h40435293, 32'hFFF00093,
                                 32'h0020E463, 32'h00000000, 32'h123452B7, 32'h0020A423,
                                 32'h02000033, 32'h010000EF, 32'h4000F093};
   logic [3:0]  v_op  [NV] = '{4'h0, 4'h8, 4'hD, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7};
   logic [4:0]  v_rs1 [NV] = '{5'd1, 5'd1, 5'd6, 5'd0, 5'd1, 5'd0, 5'd8, 5'd1, 5'd0, 5'd0, 5'd1};
   logic [4:0]  v_rs2 [NV] = '{5'd2, 5'd2, 5'd4, 5'd31, 5'd2, 5'd0, 5'd3, 5'd2, 5'd0, 5'd16, 5'd0};
   logic [4:0]  v_rd  [NV] = '{5'd3, 5'd3, 5'd5, 5'd1, 5'd8, 5'd0, 5'd5, 5'd8, 5'd0, 5'd1, 5'd1};
   logic [31:0] v_imm [NV] = '{32'h0, 32'h0, 32'h4, 32'hFFFFFFFF, 32'h8, 32'h0, 32'h12345000,
                               32'h8, 32'h0, 32'h10, 32'h400};
   logic        v_op2 [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic        v_rw  [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic        v_ill [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   logic [W-1:0] exp_q [$];

   rv32_decode_stage dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .flush_in        (flush_in),
      .in_valid_in     (in_valid_in),
      .in_ready_out    (in_ready_out),
      .instr_in        (instr_in),
      .pc_in           (pc_in),
      .out_valid_out   (out_valid_out),
      .out_ready_in    (out_ready_in),
      .pc_out          (pc_out),
      .alu_opcode_out  (alu_opcode_out),
      .rs1_addr_out    (rs1_addr_out),
      .rs2_addr_out    (rs2_addr_out),
      .rd_addr_out     (rd_addr_out),
      .imm_out         (imm_out),
      .op2_sel_imm_out (op2_sel_imm_out),
      .reg_write_out   (reg_write_out),
      .illegal_out     (illegal_out)
   );

   // Clock: 10 ns period; inputs driven and outputs sampled on the falling edge.
   always #5 clk_in = ~clk_in;

   task automatic drive_vec(input int i);
      in_valid_in = 1'b1;
      instr_in    = v_instr[i];
      pc_in       = 32'h1000 + 32'(i * 4);
   endtask

   task automatic drive_idle();
      in_valid_in = 1'b0;
      instr_in    = 32'h0;
      pc_in       = 32'h0;
   endtask

   task automatic test_reset();
      rst_n_in     = 1'b0;
      flush_in     = 1'b0;
      out_ready_in = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk_in);
      checks++;
      if ({in_ready_out, out_valid_out, pc_out, alu_opcode_out, rs1_addr_out, rs2_addr_out,
           rd_addr_out, imm_out, op2_sel_imm_out, reg_write_out, illegal_out} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: ready=%b valid=%b pc=%h imm=%h rw=%b ill=%b, required all 0",
                  in_ready_out, out_valid_out, pc_out, imm_out, reg_write_out, illegal_out);
      end
      rst_n_in = 1'b1;
      @(negedge clk_in);
      checks++;
      if (in_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b, required 1", in_ready_out);
      end
   endtask

   task automatic test_decode();
      out_ready_in = 1'b1;
      for (int i = 0; i <= NV; i++) begin
         if (i > 0) begin
            int k;
            k = i - 1;
            checks++;
            if (out_valid_out !== 1'b1) begin
               failures++;
               $display("FAIL decode_valid[%0d]: got %b, required 1", k, out_valid_out);
            end
            checks++;
            if (pc_out !== 32'h1000 + 32'(k * 4)) begin
               failures++;
               $display("FAIL decode_pc[%0d]: got %h, required %h", k, pc_out, 32'h1000 + 32'(k * 4));
            end
            checks++;
            if (alu_opcode_out !== v_op[k]) begin
               failures++;
               $display("FAIL decode_opcode[%0d]: got %b, required %b", k, alu_opcode_out, v_op[k]);
            end
            checks++;
            if ({rs1_addr_out, rs2_addr_out, rd_addr_out} !== {v_rs1[k], v_rs2[k], v_rd[k]}) begin
               failures++;
               $display("FAIL decode_regs[%0d]: got rs1=%0d rs2=%0d rd=%0d, required %0d %0d %0d", k,
                        rs1_addr_out, rs2_addr_out, rd_addr_out, v_rs1[k], v_rs2[k], v_rd[k]);
            end
            checks++;
            if (imm_out !== v_imm[k]) begin
               failures++;
               $display("FAIL decode_imm[%0d]: got %h, required %h", k, imm_out, v_imm[k]);
            end
            checks++;
            if ({op2_sel_imm_out, reg_write_out, illegal_out} !== {v_op2[k], v_rw[k], v_ill[k]}) begin
               failures++;
               $display("FAIL decode_flags[%0d]: got op2=%b rw=%b ill=%b, required %b %b %b", k,
                        op2_sel_imm_out, reg_write_out, illegal_out, v_op2[k], v_rw[k], v_ill[k]);
            end
         end
         if (i < NV) begin
            drive_vec(i);
            #1;
            checks++;
            if (in_ready_out !== 1'b1) begin
               failures++;
               $display("FAIL decode_ready[%0d]: got %b, required 1", i, in_ready_out);
            end
         end else begin
            drive_idle();
         end
         @(negedge clk_in);
      end
      checks++;
      if (out_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL decode_drain: valid got %b, required 0", out_valid_out);
      end
   endtask

   task automatic test_back_to_back();
      int idx_list [4] = '{0, 2, 4, 6};
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      logic        prev_hold = 1'b0;
      logic [31:0] prev_pc   = '0;
      logic [31:0] prev_imm  = '0;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      exp_q.delete();
      while (recv < 4 && cyc < 60) begin
         out_ready_in = (cyc >= 5);
         if (sent < 4) drive_vec(idx_list[sent]);
         else          drive_idle();
         #1;
         if (prev_hold && out_valid_out) begin
            checks++;
            if (pc_out !== prev_pc || imm_out !== prev_imm) begin
               failures++;
               $display("FAIL hold_stable: pc=%h imm=%h, required pc=%h imm=%h",
                        pc_out, imm_out, prev_pc, prev_imm);
            end
         end
         prev_hold = out_valid_out && !out_ready_in;
         prev_pc   = pc_out;
         prev_imm  = imm_out;
         if (out_valid_out && out_ready_in) begin
            got = {pc_out, alu_opcode_out, rd_addr_out};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL stream_extra: got pc=%h, required no output", pc_out);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  failures++;
                  $display("FAIL stream_word: got %h, required %h", got, exp);
               end
            end
            recv++;
         end
         if (in_valid_in && in_ready_out) begin
            exp_q.push_back({32'h1000 + 32'(idx_list[sent] * 4), v_op[idx_list[sent]],
                             v_rd[idx_list[sent]]});
            sent++;
         end
         @(negedge clk_in);
         cyc++;
      end
      drive_idle();
      checks++;
      if (recv != 4 || sent != 4) begin
         failures++;
         $display("FAIL stream_count: sent=%0d received=%0d, required 4 and 4", sent, recv);
      end
      checks++;
      if (out_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL stream_no_dup: valid got %b, required 0", out_valid_out);
      end
   endtask

   task automatic test_flush();
      out_ready_in = 1'b0;
      drive_vec(1);
      @(negedge clk_in);
      drive_idle();
      checks++;
      if (out_valid_out !== 1'b1) begin
         failures++;
         $display("FAIL flush_setup_valid: got %b, required 1", out_valid_out);
      end
      out_ready_in = 1'b1;
      flush_in     = 1'b1;
      drive_vec(3);
      #1;
      checks++;
      if (in_ready_out !== 1'b0) begin
         failures++;
         $display("FAIL flush_ready: got %b, required 0", in_ready_out);
      end
      @(negedge clk_in);
      flush_in = 1'b0;
      drive_idle();
      checks++;
      if (out_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL flush_valid: got %b, required 0", out_valid_out);
      end
      @(negedge clk_in);
      checks++;
      if (out_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL flush_no_accept: valid got %b, required 0", out_valid_out);
      end
   endtask

   task automatic test_reset_mid();
      out_ready_in = 1'b0;
      drive_vec(3);
      @(negedge clk_in);
      drive_idle();
      checks++;
      if (out_valid_out !== 1'b1 || imm_out !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL rst_mid_setup: valid=%b imm=%h, required 1 ffffffff", out_valid_out, imm_out);
      end
      rst_n_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if ({in_ready_out, out_valid_out, pc_out, alu_opcode_out, rs1_addr_out, rs2_addr_out,
           rd_addr_out, imm_out, op2_sel_imm_out, reg_write_out, illegal_out} !== '0) begin
         failures++;
         $display("FAIL rst_mid_outputs: ready=%b valid=%b pc=%h imm=%h rd=%0d rw=%b, required all 0",
                  in_ready_out, out_valid_out, pc_out, imm_out, rd_addr_out, reg_write_out);
      end
      rst_n_in = 1'b1;
      @(negedge clk_in);
      checks++;
      if (in_ready_out !== 1'b1 || out_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_release: ready=%b valid=%b, required 1 0", in_ready_out, out_valid_out);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
